dma_wchan_gen: RTL and testbench
================================

# dma_wchan_gen

Write-channel generator that sits directly downstream of `dma_shift_aligner`. It buffers the aligned data beats (`fifo_data`) and the per-burst strobe requests (`strb_valid`/`strb`) that the aligner produces. It then drives the AXI W channel toward the destination with per-beat `wstrb` and `wlast`, under full valid/ready backpressure. The block decouples the aligner's free-running output from AXI slave stalls.

## Interface
Parameters:
- `DATA_DEPTH`, 8: data FIFO entries (power of 2, ≥2).
- `REQ_DEPTH`, 4: strobe-request FIFO entries (power of 2, ≥2).

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rstn` in 1: asynchronous active-low reset.
- `data_valid_i` in 1: aligned beat present (aligner `fifo_data_o`).
- `data_i` in `axi_data_t` (512): aligned beat.
- `data_ready_o` out 1: data FIFO not full.
- `strb_valid_i` in 1: burst strobe request (aligner `strb_valid_o`).
- `strb_i` in `s_dma_strb_req_t`: fields `head`[5:0], `tail`[5:0], `alen`[7:0].
- `strb_ready_o` out 1: request FIFO not full.
- `wvalid_o` out 1: AXI W valid.
- `wdata_o` out 512: AXI W data.
- `wstrb_o` out 64: AXI W strobe.
- `wlast_o` out 1: last beat of the burst.
- `wready_i` in 1: AXI W ready.
- `busy_o` out 1: any FIFO non-empty, or FSM not IDLE.
- `err_o` out 1: sticky; set on overflow push or on an illegal request.

## Operation
- Data FIFO: pushes on `data_valid_i & data_ready_o`. A push while full is dropped and sets `err_o`.
- Request FIFO: pushes on `strb_valid_i & strb_ready_o`. A push while full is dropped and sets `err_o`.
- FSM states:
  - IDLE → BURST when the request FIFO is non-empty. On that transition, latch head, tail and alen, and clear `beat_cnt`[7:0] to 0.
  - BURST: `wvalid_o = data FIFO non-empty`.
  - On each `wvalid_o & wready_i`, pop the data FIFO.
  - If `beat_cnt == alen`: pop the request FIFO. Go to BURST with the next request (no idle cycle) if one is present at that edge; otherwise go to IDLE.
  - Else: increment `beat_cnt`.
- Strobe per beat (byte b, 0..63):
  - `alen==0`: b ≥ head and b ≤ tail.
  - First beat of a multi-beat burst: b ≥ head.
  - Last beat: b ≤ tail.
  - Middle beats: all ones.
- `wlast_o = (beat_cnt == alen)` while in BURST.
- Illegal request: `alen==0` with head > tail. The burst still issues one beat with `wstrb_o = 0`, and `err_o` is set.
- Outputs are stable while `wvalid_o & !wready_i`. `wvalid_o` never deasserts without a handshake.
- Simultaneous push and pop on a full FIFO: the push is accepted; occupancy is unchanged.
- Simultaneous push and pop on an empty FIFO: the data is not bypassed; it appears next cycle.
- Reset mid-burst: both FIFOs are flushed, the FSM goes to IDLE, and `err_o` clears. The partial burst is abandoned.

## Timing
- Reset values:
  - `wvalid_o`, `wlast_o`, `wstrb_o`, `wdata_o`, `err_o`, `busy_o` = 0.
  - `data_ready_o`, `strb_ready_o` = 1.
- Latency: a beat and its request pushed at edge N give `wvalid_o` high after edge N+1 (two-cycle minimum: request pop into FSM, then data head).
- Throughput: one beat per cycle while `wready_i` is high and data is available, including across burst boundaries.
- Ready outputs are derived from the registered FIFO count only. There is no combinational path from `wready_i`.
- `wdata_o`, `wstrb_o` and `wlast_o` come from FIFO head/FSM registers. No combinational path from inputs.

## Structure
- In `dma_pkg`: `s_dma_strb_req_t`; constants `DMA_BEAT_BYTES=64` and `DMA_OFS_W=6`; FSM enum `e_wchan_state_t` {IDLE, BURST}.
- `axi_data_t` comes from `venus_soc_pkg`.
- One sub-module: `dma_sync_fifo` (parameterized width/depth, count output), instantiated twice (data, request).
- Strobe mask generation is a function in `dma_pkg` (`dma_byte_mask(head, tail)`).

## Test plan
- Request head=3, tail=7, alen=3; data beats 0xFFFF…, 0xEEEE…, 0x8888…, 0x3333…; `wready_i`=1 → four beats:
  - `wstrb_o` = 64'hFFFF_FFFF_FFFF_FFF8, all-ones, all-ones, 64'h0000_0000_0000_00FF.
  - `wlast_o` only on beat 3.
  - Data is in order.
- Request head=13, tail=13, alen=0 → one beat with `wstrb_o` = 64'h0000_0000_0000_2000 and `wlast_o`=1.
- Same 4-beat burst with `wready_i` toggling every other cycle → outputs hold during stalls; the same four strobes are issued; no beat is lost.
- Push 9 beats with `wready_i`=0 (DATA_DEPTH=8) → `data_ready_o` falls after the 8th push; the 9th push sets `err_o`; the FIFO holds the first 8 beats.
- Two back-to-back requests (alen=1, then alen=0) with data present → three consecutive handshake cycles and no IDLE bubble; `wlast_o` on beats 1 and 2.
- Assert `rstn`=0 mid-burst after beat 1 → all outputs return to reset values; the next request starts cleanly at beat 0.

Source files
------------

// File: rtl/dma_pkg.sv
// DMA write-channel types, constants and the byte-strobe helper.
package dma_pkg;
  localparam int DMA_BEAT_BYTES = 64;
  localparam int DMA_OFS_W      = 6;

  typedef struct packed {
    logic [DMA_OFS_W-1:0] head;
    logic [DMA_OFS_W-1:0] tail;
    logic [7:0]           alen;
  } s_dma_strb_req_t;

  typedef enum logic {IDLE, BURST} e_wchan_state_t;

  // Bytes head..tail inclusive; head > tail yields an empty mask.
  function automatic logic [DMA_BEAT_BYTES-1:0] dma_byte_mask(input logic [DMA_OFS_W-1:0] head,
                                                             input logic [DMA_OFS_W-1:0] tail);
    logic [DMA_BEAT_BYTES-1:0] m;
    m = '0;
    for (int b = 0; b < DMA_BEAT_BYTES; b++) begin
      m[b] = (DMA_OFS_W'(b) >= head) && (DMA_OFS_W'(b) <= tail);
    end
    return m;
  endfunction
endpackage

// File: rtl/venus_soc_pkg.sv
// SoC-wide bus types shared by the DMA datapath.
package venus_soc_pkg;
  localparam int AXI_DATA_W = 512;
  typedef logic [AXI_DATA_W-1:0] axi_data_t;
endpackage

// File: rtl/dma_wchan_gen_if.sv
// Aligner-side push streams plus the AXI W channel of the write-channel generator.
interface dma_wchan_gen_if;
  import venus_soc_pkg::*;
  import dma_pkg::*;

  logic                      data_valid_i;
  axi_data_t                 data_i;
  logic                      data_ready_o;
  logic                      strb_valid_i;
  s_dma_strb_req_t           strb_i;
  logic                      strb_ready_o;
  logic                      wvalid_o;
  axi_data_t                 wdata_o;
  logic [DMA_BEAT_BYTES-1:0] wstrb_o;
  logic                      wlast_o;
  logic                      wready_i;

  modport slave (
    input  data_valid_i, data_i, strb_valid_i, strb_i, wready_i,
    output data_ready_o, strb_ready_o, wvalid_o, wdata_o, wstrb_o, wlast_o
  );

  modport master (
    output data_valid_i, data_i, strb_valid_i, strb_i, wready_i,
    input  data_ready_o, strb_ready_o, wvalid_o, wdata_o, wstrb_o, wlast_o
  );
endinterface

// File: rtl/dma_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; a push while full is
// accepted only when a pop frees the slot in the same cycle, else it is dropped.
module dma_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     overflow_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full, do_push, do_pop;

  assign full       = count_q == (AW+1)'(DEPTH);
  assign empty_o    = count_q == '0;
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full || do_pop);
  assign overflow_o = push_i && full && !do_pop;
  assign count_o    = count_q;
  assign rdata_o    = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define valid contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/dma_wchan_gen.sv
// Buffers aligned beats and burst strobe requests and replays them as AXI W
// beats with per-beat wstrb/wlast under full backpressure.
module dma_wchan_gen
  import venus_soc_pkg::*;
  import dma_pkg::*;
#(
  parameter int DATA_DEPTH = 8,
  parameter int REQ_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rstn,
  dma_wchan_gen_if.slave  bus,
  output logic            busy_o,
  output logic            err_o
);
  localparam int DAW   = $clog2(DATA_DEPTH);
  localparam int RAW   = $clog2(REQ_DEPTH);
  localparam int REQ_W = $bits(s_dma_strb_req_t);

  logic [DAW:0]    data_cnt;
  logic            data_empty, data_ovf, data_pop;
  axi_data_t       data_head;
  logic [RAW:0]    req_cnt;
  logic            req_empty, req_ovf, req_pop;
  s_dma_strb_req_t req_head;

  e_wchan_state_t  state_q, state_d;
  s_dma_strb_req_t cur_q, cur_d;
  logic [7:0]      beat_cnt_q, beat_cnt_d;
  logic            err_q, err_d;
  logic            fire, last_beat, illegal_load;
  logic [DMA_OFS_W-1:0] mask_lo, mask_hi;

  dma_sync_fifo #(.WIDTH($bits(axi_data_t)), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk, .rstn,
    .push_i(bus.data_valid_i), .wdata_i(bus.data_i), .pop_i(data_pop),
    .rdata_o(data_head), .count_o(data_cnt), .empty_o(data_empty), .overflow_o(data_ovf)
  );

  dma_sync_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk, .rstn,
    .push_i(bus.strb_valid_i), .wdata_i(bus.strb_i), .pop_i(req_pop),
    .rdata_o(req_head), .count_o(req_cnt), .empty_o(req_empty), .overflow_o(req_ovf)
  );

  // Ready looks only at the registered count, never at wready_i.
  assign bus.data_ready_o = data_cnt != (DAW+1)'(DATA_DEPTH);
  assign bus.strb_ready_o = req_cnt != (RAW+1)'(REQ_DEPTH);

  assign bus.wvalid_o = (state_q == BURST) && !data_empty;
  assign last_beat    = beat_cnt_q == cur_q.alen;
  assign fire         = bus.wvalid_o && bus.wready_i;
  assign data_pop     = fire;

  // The request is popped as it is latched, so the next one is already at the head.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    beat_cnt_d = beat_cnt_q;
    req_pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!req_empty) begin
          req_pop    = 1'b1;
          cur_d      = req_head;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (fire) begin
          if (last_beat) begin
            beat_cnt_d = '0;
            if (!req_empty) begin
              req_pop = 1'b1;
              cur_d   = req_head;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
    endcase
  end

  assign illegal_load = req_pop && (req_head.alen == '0) && (req_head.head > req_head.tail);
  assign err_d        = err_q || data_ovf || req_ovf || illegal_load;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  // First beat trims below head, last beat trims above tail; a one-beat burst does both.
  assign mask_lo     = (beat_cnt_q == '0) ? cur_q.head : '0;
  assign mask_hi     = last_beat ? cur_q.tail : '1;
  assign bus.wstrb_o = bus.wvalid_o ? dma_byte_mask(mask_lo, mask_hi) : '0;
  assign bus.wdata_o = bus.wvalid_o ? data_head : '0;
  assign bus.wlast_o = (state_q == BURST) && last_beat;

  assign busy_o = !data_empty || !req_empty || (state_q != IDLE);
  assign err_o  = err_q;
endmodule

// File: tb/tb_dma_wchan_gen.sv
// Directed bench for dma_wchan_gen: strobe shaping, backpressure, overflow,
// back-to-back bursts, illegal requests and mid-burst reset.
module tb_dma_wchan_gen;
  import dma_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic busy, err;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  dma_wchan_gen_if bus ();

  dma_wchan_gen #(.DATA_DEPTH(8), .REQ_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .busy_o(busy), .err_o(err)
  );

  typedef struct {
    logic [511:0] d;
    logic [63:0]  s;
    logic         l;
    int           cyc;
  } beat_t;

  beat_t beats[$];

  localparam logic [511:0] D_FF = {64{8'hFF}};
  localparam logic [511:0] D_EE = {64{8'hEE}};
  localparam logic [511:0] D_88 = {64{8'h88}};
  localparam logic [511:0] D_33 = {64{8'h33}};
  localparam logic [63:0]  ONES = {64{1'b1}};

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshakes are recorded half a cycle before the edge that completes them;
  // any beat that was stalled must reappear unchanged.
  logic         st_v = 1'b0;
  logic [511:0] st_d;
  logic [63:0]  st_s;
  logic         st_l;
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      st_v = 1'b0;
    end else begin
      if (st_v) begin
        check("hold_valid", bus.wvalid_o, 1);
        check("hold_data",  bus.wdata_o,  st_d);
        check("hold_strb",  bus.wstrb_o,  st_s);
        check("hold_last",  bus.wlast_o,  st_l);
      end
      if (bus.wvalid_o && bus.wready_i)
        beats.push_back('{bus.wdata_o, bus.wstrb_o, bus.wlast_o, cyc});
      st_v = bus.wvalid_o && !bus.wready_i;
      st_d = bus.wdata_o;
      st_s = bus.wstrb_o;
      st_l = bus.wlast_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [5:0] h, input logic [5:0] t, input logic [7:0] a);
    bus.strb_valid_i = 1'b1;
    bus.strb_i       = '{head: h, tail: t, alen: a};
    tick();
    bus.strb_valid_i = 1'b0;
  endtask

  task automatic push_data(input logic [511:0] d);
    bus.data_valid_i = 1'b1;
    bus.data_i       = d;
    tick();
    bus.data_valid_i = 1'b0;
  endtask

  task automatic wait_beats(input int n, input string tag);
    int k = 0;
    while (beats.size() < n && k < 200) begin
      tick();
      k++;
    end
    check(tag, beats.size(), n);
  endtask

  task automatic check_beat(input string tag, input int i, input logic [511:0] d,
                            input logic [63:0] s, input logic l);
    check({tag, "_data"}, beats[i].d, d);
    check({tag, "_strb"}, beats[i].s, s);
    check({tag, "_last"}, beats[i].l, l);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wvalid"}, bus.wvalid_o, 0);
    check({tag, "_wlast"},  bus.wlast_o,  0);
    check({tag, "_wstrb"},  bus.wstrb_o,  0);
    check({tag, "_wdata"},  bus.wdata_o,  0);
    check({tag, "_err"},    err,          0);
    check({tag, "_busy"},   busy,         0);
    check({tag, "_dready"}, bus.data_ready_o, 1);
    check({tag, "_sready"}, bus.strb_ready_o, 1);
  endtask

  function automatic logic [511:0] pat(input int i);
    return {64{8'(8'h10 + i)}};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.data_valid_i = 1'b0;
    bus.data_i       = '0;
    bus.strb_valid_i = 1'b0;
    bus.strb_i       = '0;
    bus.wready_i     = 1'b0;

    // Reset values, during and after reset.
    tick(); tick();
    check_idle_outputs("rst_in");
    rstn = 1'b1;
    tick();
    check_idle_outputs("rst_out");

    // Four-beat burst at full throughput.
    bus.wready_i = 1'b1;
    push_req(6'd3, 6'd7, 8'd3);
    push_data(D_FF); push_data(D_EE); push_data(D_88); push_data(D_33);
    wait_beats(4, "b4_count");
    check_beat("b4_0", 0, D_FF, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    check_beat("b4_1", 1, D_EE, ONES,                    1'b0);
    check_beat("b4_2", 2, D_88, ONES,                    1'b0);
    check_beat("b4_3", 3, D_33, 64'h0000_0000_0000_00FF, 1'b1);
    tick(); tick();
    check("b4_busy_after", busy, 0);

    // Single-beat burst: latency, strobe and one stalled cycle.
    beats.delete();
    bus.wready_i     = 1'b0;
    bus.strb_valid_i = 1'b1;
    bus.strb_i       = '{head: 6'd13, tail: 6'd13, alen: 8'd0};
    bus.data_valid_i = 1'b1;
    bus.data_i       = D_EE;
    tick();
    bus.strb_valid_i = 1'b0;
    bus.data_valid_i = 1'b0;
    check("lat_edge_n_wvalid", bus.wvalid_o, 0);
    tick();
    check("lat_edge_n1_wvalid", bus.wvalid_o, 1);
    check("lat_edge_n1_wstrb",  bus.wstrb_o, 64'h0000_0000_0000_2000);
    check("lat_edge_n1_wlast",  bus.wlast_o, 1);
    tick();
    bus.wready_i = 1'b1;
    wait_beats(1, "b1_count");
    check_beat("b1", 0, D_EE, 64'h0000_0000_0000_2000, 1'b1);
    check("b1_wvalid_after", bus.wvalid_o, 0);

    // Same four-beat burst with wready toggling.
    beats.delete();
    bus.wready_i = 1'b0;
    push_req(6'd3, 6'd7, 8'd3);
    push_data(D_FF); push_data(D_EE); push_data(D_88); push_data(D_33);
    for (int i = 0; i < 24 && beats.size() < 4; i++) begin
      bus.wready_i = i[0];
      tick();
    end
    bus.wready_i = 1'b0;
    check("tog_count", beats.size(), 4);
    if (beats.size() == 4) begin
      check_beat("tog_0", 0, D_FF, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
      check_beat("tog_1", 1, D_EE, ONES,                    1'b0);
      check_beat("tog_2", 2, D_88, ONES,                    1'b0);
      check_beat("tog_3", 3, D_33, 64'h0000_0000_0000_00FF, 1'b1);
    end

    // Back-to-back bursts (alen=1 then alen=0) with no idle bubble.
    beats.delete();
    push_req(6'd2, 6'd10, 8'd1);
    push_req(6'd5, 6'd9,  8'd0);
    push_data(D_FF); push_data(D_88); push_data(D_33);
    bus.wready_i = 1'b1;
    wait_beats(3, "b2b_count");
    bus.wready_i = 1'b0;
    if (beats.size() == 3) begin
      check_beat("b2b_0", 0, D_FF, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
      check_beat("b2b_1", 1, D_88, 64'h0000_0000_0000_07FF, 1'b1);
      check_beat("b2b_2", 2, D_33, 64'h0000_0000_0000_03E0, 1'b1);
      check("b2b_gap1", beats[1].cyc - beats[0].cyc, 1);
      check("b2b_gap2", beats[2].cyc - beats[1].cyc, 1);
    end

    // Overflow: eight beats fill the FIFO, the ninth is dropped and flags err.
    beats.delete();
    for (int i = 0; i < 8; i++) begin
      push_data(pat(i));
      check("ovf_ready", bus.data_ready_o, (i < 7) ? 1'b1 : 1'b0);
    end
    check("ovf_err_before", err, 0);
    push_data(pat(8));
    check("ovf_err_after",   err, 1);
    check("ovf_ready_after", bus.data_ready_o, 0);
    push_req(6'd0, 6'd63, 8'd7);
    bus.wready_i = 1'b1;
    wait_beats(8, "ovf_drain_count");
    tick(); tick(); tick();
    check("ovf_no_ninth", beats.size(), 8);
    if (beats.size() == 8) begin
      for (int i = 0; i < 8; i++)
        check_beat("ovf_beat", i, pat(i), ONES, (i == 7) ? 1'b1 : 1'b0);
    end

    // Reset after beat 1 of a four-beat burst.
    beats.delete();
    bus.wready_i = 1'b0;
    push_req(6'd3, 6'd7, 8'd3);
    push_data(D_FF); push_data(D_EE); push_data(D_88); push_data(D_33);
    bus.wready_i = 1'b1;
    wait_beats(2, "mid_pre_count");
    bus.wready_i = 1'b0;
    rstn = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    tick();
    rstn = 1'b1;
    tick();
    check_idle_outputs("mid_post");
    beats.delete();
    push_req(6'd4, 6'd60, 8'd1);
    push_data(D_88); push_data(D_33);
    bus.wready_i = 1'b1;
    wait_beats(2, "mid_next_count");
    tick(); tick();
    check("mid_next_total", beats.size(), 2);
    if (beats.size() >= 2) begin
      check_beat("mid_next_0", 0, D_88, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
      check_beat("mid_next_1", 1, D_33, 64'h1FFF_FFFF_FFFF_FFFF, 1'b1);
    end
    check("mid_next_err", err, 0);

    // Illegal request: one empty-strobe beat, err set.
    beats.delete();
    push_req(6'd9, 6'd4, 8'd0);
    push_data(D_EE);
    wait_beats(1, "ill_count");
    if (beats.size() == 1)
      check_beat("ill", 0, D_EE, 64'h0, 1'b1);
    check("ill_err", err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
